// File: rtl/i2f_pkg.sv
// i2f_pkg: shared FSM encoding and FP32 field constants for the integer-to-float converter.
package i2f_pkg;
  typedef enum logic [2:0] {GET_A, CONVERT, NORMALISE, ROUND, PACK, PUT_Z} state_t;
  localparam int FP32_BIAS = 127;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int INT_W = 32;
endpackage

// File: rtl/lzc32.sv
// lzc32: combinational leading-zero counter; reports 32 for an all-zero word.
module lzc32 (
  input  logic [31:0] a,
  output logic [5:0]  count
);
  always_comb begin
    count = 6'd32;
    for (int i = 0; i < 32; i++)
      if (a[i]) count = 6'(31 - i);
  end
endmodule

// File: rtl/int_to_float.sv
// int_to_float: stb/ack responder converting a 32-bit integer to IEEE-754 single (round to nearest even).
// Define I2F_STATUS_EN to add the output_z_inexact status port.
module int_to_float
  import i2f_pkg::*;
#(
  parameter bit INPUT_SIGNED = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [INT_W-1:0]    input_a,
  input  logic                input_a_stb,
  output logic                input_a_ack,
  output logic [31:0]         output_z,
  output logic                output_z_stb,
  input  logic                output_z_ack
`ifdef I2F_STATUS_EN
  ,output logic               output_z_inexact
`endif
);
  state_t state;
  logic [INT_W-1:0] a, mag, m;
  logic sign, zero;
  logic [EXP_W-1:0] e;
  logic [FRAC_W-1:0] frac;
  logic [5:0] lz;
  logic [23:0] rnd;
  lzc32 u_lzc (.a(mag), .count(lz));
  assign rnd = m[31:8] + 24'(m[7] & (m[6] | (|m[5:0]) | m[8]));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= GET_A;
      input_a_ack <= 1'b0;
      output_z_stb <= 1'b0;
      output_z <= '0;
      a <= '0;
      mag <= '0;
      m <= '0;
      sign <= 1'b0;
      zero <= 1'b0;
      e <= '0;
      frac <= '0;
`ifdef I2F_STATUS_EN
      output_z_inexact <= 1'b0;
`endif
    end else begin
      case (state)
        GET_A: begin
          if (input_a_ack && input_a_stb) begin
            a <= input_a;
            input_a_ack <= 1'b0;
            state <= CONVERT;
          end else input_a_ack <= 1'b1;
        end
        CONVERT: begin
          sign <= a[31] & INPUT_SIGNED;
          mag <= (a[31] & INPUT_SIGNED) ? -a : a;
          zero <= (a == '0);
          state <= NORMALISE;
        end
        NORMALISE: begin
          m <= mag << lz;
          e <= 8'(FP32_BIAS + INT_W - 1) - {2'b00, lz};
          state <= ROUND;
        end
        ROUND: begin
          // m[31] is set, so a cleared leading bit after rounding means the carry rippled out
          frac <= rnd[22:0];
          e <= e + {7'b0, ~rnd[23]};
          state <= PACK;
        end
        PACK: begin
          output_z <= zero ? '0 : {sign, e, frac};
          output_z_stb <= 1'b1;
`ifdef I2F_STATUS_EN
          output_z_inexact <= |m[7:0];
`endif
          state <= PUT_Z;
        end
        PUT_Z: begin
          if (output_z_ack) begin
            output_z_stb <= 1'b0;
            input_a_ack <= 1'b1;
`ifdef I2F_STATUS_EN
            output_z_inexact <= 1'b0;
`endif
            state <= GET_A;
          end
        end
        default: state <= GET_A;
      endcase
    end
  end
endmodule

// File: tb/tb_int_to_float.sv
// tb_int_to_float: signed and unsigned converters run in lockstep against an arithmetic rounding model.
module tb_int_to_float;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] input_a = '0;
  logic input_a_stb = 1'b0, output_z_ack = 1'b0;
  logic s_ack, u_ack, s_stb, u_stb;
  logic [31:0] zs, zu, last_zs, last_zu;
  int checks = 0, errors = 0;
`ifdef I2F_STATUS_EN
  logic s_inx, u_inx;
`endif
  always #5 clk = ~clk;

  int_to_float #(.INPUT_SIGNED(1'b1)) u_s (
    .clk(clk), .rst(rst), .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(s_ack),
    .output_z(zs), .output_z_stb(s_stb), .output_z_ack(output_z_ack)
`ifdef I2F_STATUS_EN
    , .output_z_inexact(s_inx)
`endif
  );
  int_to_float #(.INPUT_SIGNED(1'b0)) u_u (
    .clk(clk), .rst(rst), .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(u_ack),
    .output_z(zu), .output_z_stb(u_stb), .output_z_ack(output_z_ack)
`ifdef I2F_STATUS_EN
    , .output_z_inexact(u_inx)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // returns {inexact, fp32 bits}
  function automatic logic [32:0] ref_f(input logic [31:0] a, input bit sgn);
    logic s;
    longint unsigned mg, q, rem, half;
    int p, sh;
    bit inx;
    s = sgn & a[31];
    mg = s ? (64'd1 << 32) - {32'd0, a} : {32'd0, a};
    if (mg == 0) return '0;
    p = 0;
    for (int i = 0; i < 33; i++) if (mg[i]) p = i;
    inx = 0;
    if (p <= 23) q = mg << (23 - p);
    else begin
      sh = p - 23;
      q = mg >> sh;
      rem = mg - (q << sh);
      half = 64'd1 << (sh - 1);
      inx = (rem != 0);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin q = q >> 1; p++; end
    end
    return {inx, s, 8'(p + 127), q[22:0]};
  endfunction

  task automatic send(input logic [31:0] a);
    int n = 0;
    while (!(s_ack && u_ack) && n < 20) begin @(negedge clk); n++; end
    chk("ack_wait", 32'(n < 20), 32'd1);
    input_a = a;
    input_a_stb = 1'b1;
    @(negedge clk);
    input_a_stb = 1'b0;
  endtask

  task automatic get(input logic [31:0] a, input int hold);
    int n = 0;
    logic [32:0] es, eu;
    es = ref_f(a, 1'b1);
    eu = ref_f(a, 1'b0);
    while (!s_stb && n < 10) begin @(negedge clk); n++; end
    chk("latency", 32'(n), 32'd4);
    chk("stb_u", 32'(u_stb), 32'd1);
    chk("z_signed", zs, es[31:0]);
    chk("z_unsigned", zu, eu[31:0]);
`ifdef I2F_STATUS_EN
    chk("inexact_s", 32'(s_inx), 32'(es[32]));
    chk("inexact_u", 32'(u_inx), 32'(eu[32]));
`endif
    last_zs = zs;
    last_zu = zu;
    for (int k = 0; k < hold; k++) begin
      input_a_stb = 1'b1;
      input_a = ~a;
      @(negedge clk);
      chk("hold_z", zs, last_zs);
      chk("hold_stb", 32'(s_stb), 32'd1);
      chk("hold_ack", 32'(s_ack), 32'd0);
    end
    output_z_ack = 1'b1;
    @(negedge clk);
    output_z_ack = 1'b0;
    input_a_stb = 1'b0;
    chk("stb_drop", 32'(s_stb), 32'd0);
    chk("ack_back", 32'(s_ack), 32'd1);
  endtask

  logic [31:0] dir_a [7] = '{32'd1, 32'hFFFFFFFF, 32'd0, 32'h7FFFFFFF, 32'h80000000, 32'd16777217, 32'd16777219};
  logic [31:0] dir_z [7] = '{32'h3F800000, 32'hBF800000, 32'h0, 32'h4F000000, 32'hCF000000, 32'h4B800000, 32'h4B800002};

  initial begin
    logic [31:0] r;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(s_ack), 32'd0);
    chk("rst_stb", 32'(s_stb), 32'd0);
    chk("rst_z", zs, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ack_after_rst", 32'(s_ack), 32'd1);
    for (int i = 0; i < 7; i++) begin
      send(dir_a[i]);
      get(dir_a[i], 0);
      chk("spec_signed", last_zs, dir_z[i]);
    end
    send(32'hFFFFFFFF);
    get(32'hFFFFFFFF, 0);
    chk("spec_u_max", last_zu, 32'h4F800000);
    send(32'h80000000);
    get(32'h80000000, 0);
    chk("spec_u_min", last_zu, 32'h4F000000);
    send(32'd12345);
    get(32'd12345, 10);
    send(32'd99);
    get(32'd99, 0);
    send(32'd777);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_stb", 32'(s_stb), 32'd0);
    chk("midrst_ack", 32'(s_ack), 32'd0);
    chk("midrst_z", zs, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send(32'd5);
    get(32'd5, 0);
    chk("after_rst", last_zs, 32'h40A00000);
    for (int i = 0; i < 200; i++) begin
      r = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) r = -r;
      send(r);
      get(r, (i % 17 == 0) ? 2 : 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
